// File: rtl/gamma_table_rom.sv
// rtl/gamma_table_rom.sv - per-component gamma lookup, 8 curve pages, 2-cycle pipeline
module gamma_table_rom #(
  parameter int COLOR_WIDTH = 7
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic [2:0]             gamma_val,
  input  logic [COLOR_WIDTH-1:0] vdata_in,
  input  logic                   nbypass,
  output logic [COLOR_WIDTH-1:0] vdata_out
);

  localparam int MAXV  = (1 << COLOR_WIDTH) - 1;
  localparam int DEPTH = 8 << COLOR_WIDTH;
  localparam int AW    = COLOR_WIDTH + 3;

  // One curve entry: round(M * (x/M)^g), clamped to the sample range.
  // Page order puts the brightening curves (g < 1) first; the neutral curve
  // is not stored because bypass already provides it.
  function automatic logic [COLOR_WIDTH-1:0] gamma_entry(input int page, input int x);
    real g;
    real m;
    real v;
    int  r;
    m = real'(MAXV);
    case (page)
      0:       g = 0.80;
      1:       g = 0.85;
      2:       g = 0.90;
      3:       g = 0.95;
      4:       g = 1.05;
      5:       g = 1.10;
      6:       g = 1.15;
      default: g = 1.20;
    endcase
    v = m * ((real'(x) / m) ** g) + 0.5;
    r = $rtoi(v);
    if (r < 0) r = 0;
    if (r > MAXV) r = MAXV;
    return r[COLOR_WIDTH-1:0];
  endfunction

  // Read-only table, address = {page, sample}; every word is an
  // elaboration-time constant so the array maps onto a ROM.
  logic [COLOR_WIDTH-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = gamma_entry(i >> COLOR_WIDTH, i & MAXV);
  end

  // Stage 1 state. The low address bits double as the delayed sample for
  // bypass, so no separate data register is needed.
  logic [AW-1:0] addr_s1;
  logic          flag_s1;

  // Stage 1: capture page, sample and mode together so a page or mode
  // change applies to exactly the sample presented with it.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      addr_s1 <= '0;
      flag_s1 <= 1'b0;
    end else begin
      addr_s1 <= {gamma_val, vdata_in};
      flag_s1 <= nbypass;
    end
  end

  // Stage 2: synchronous table read, or the delayed sample when bypassed.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      vdata_out <= '0;
    end else if (flag_s1) begin
      vdata_out <= rom[addr_s1];
    end else begin
      vdata_out <= addr_s1[COLOR_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_gamma_table_rom.sv
// tb/tb_gamma_table_rom.sv - scoreboard bench for gamma_table_rom
module tb_gamma_table_rom;

  logic       VCLK;
  logic       nRST;
  logic [2:0] gamma_val;
  logic [6:0] vdata_in;
  logic       nbypass;
  logic [6:0] vdata_out;

  gamma_table_rom #(.COLOR_WIDTH(7)) dut (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .gamma_val (gamma_val),
    .vdata_in  (vdata_in),
    .nbypass   (nbypass),
    .vdata_out (vdata_out)
  );

  typedef struct {
    int    due;
    int    exp;
    int    page;
    int    x;
    bit    gam;
    string tag;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [6:0] got [8][128];

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  always @(posedge VCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int page, input int x);
    real g;
    real v;
    int  r;
    case (page)
      0: g = 0.80;
      1: g = 0.85;
      2: g = 0.90;
      3: g = 0.95;
      4: g = 1.05;
      5: g = 1.10;
      6: g = 1.15;
      default: g = 1.20;
    endcase
    v = $floor(127.0 * $pow(real'(x) / 127.0, g) + 0.5);
    r = $rtoi(v);
    if (r < 0) r = 0;
    if (r > 127) r = 127;
    return r;
  endfunction

  task automatic drive(input int g, input bit nb, input int x, input int exp, input string tag);
    exp_t e;
    @(posedge VCLK);
    #1;
    gamma_val = g[2:0];
    nbypass   = nb;
    vdata_in  = x[6:0];
    e.due  = cyc + 2;
    e.exp  = exp;
    e.page = g;
    e.x    = x;
    e.gam  = nb;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge VCLK);
    @(negedge VCLK);
    check("drain", sbq.size(), 0);
  endtask

  always @(negedge VCLK) begin
    if (nRST && sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      check(e.tag, vdata_out, e.exp);
      if (e.gam) got[e.page][e.x] = vdata_out;
    end
  end

  initial begin
    nRST      = 1'b0;
    gamma_val = '0;
    nbypass   = 1'b0;
    vdata_in  = '0;
    repeat (3) @(posedge VCLK);
    #1;
    check("reset_out", vdata_out, 0);
    #2;
    nRST = 1'b1;

    for (int x = 0; x < 128; x++) drive(0, 1'b0, x, x, $sformatf("bypass_%0d", x));
    drain();

    drive(0, 1'b1, 64, 73, "p0_64");
    drive(7, 1'b1, 64, 56, "p7_64");
    drain();

    for (int p = 0; p < 8; p++)
      for (int x = 0; x < 128; x++)
        drive(p, 1'b1, x, model(p, x), $sformatf("sweep_p%0d_x%0d", p, x));
    drain();

    for (int p = 0; p < 8; p++) begin
      int dec;
      dec = 0;
      check($sformatf("end0_p%0d", p), got[p][0], 0);
      check($sformatf("end127_p%0d", p), got[p][127], 127);
      for (int x = 1; x < 128; x++) if (got[p][x] < got[p][x-1]) dec++;
      check($sformatf("mono_p%0d", p), dec, 0);
    end

    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: drive(0, 1'b1, 64, 73, $sformatf("sw_%0d", i));
        1: drive(7, 1'b1, 64, 56, $sformatf("sw_%0d", i));
        default: drive(7, 1'b0, 64, 64, $sformatf("sw_%0d", i));
      endcase
    end
    drain();

    for (int x = 10; x < 16; x++) drive(3, 1'b1, x, model(3, x), "pre_rst");
    @(posedge VCLK);
    #3;
    nRST = 1'b0;
    #1;
    check("rst_async", vdata_out, 0);
    sbq.delete();
    @(posedge VCLK);
    #1;
    check("rst_hold", vdata_out, 0);
    #2;
    nRST = 1'b1;
    #1;
    check("rst_release", vdata_out, 0);
    drive(5, 1'b1, 100, model(5, 100), "post_rst_0");
    drive(2, 1'b1, 30, model(2, 30), "post_rst_1");
    drive(1, 1'b0, 77, 77, "post_rst_2");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
